// File: rtl/vote_monitor.sv
// vote_monitor: health monitor that sits behind a triple-redundant majority
// voter. It tracks per-lane disagreement runs and latches sticky lane faults.
// It also counts disagreement events and steps NORMAL -> DEGRADED -> FAILED.
// Each accepted sample yields one result bit through a one-deep output register.
// Optional feature: define VOTE_MONITOR_CLEAR_EN to add a fault_clr input that
// returns the health state to NORMAL without a full reset.
module vote_monitor #(
   parameter int THRESH = 4,  // consecutive mismatches that fault a lane (1..15)
   parameter int CNT_W  = 8   // width of err_cnt
) (
   input  logic             clk,
   input  logic             rst,
`ifdef VOTE_MONITOR_CLEAR_EN
   input  logic             fault_clr,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       lanes,
   input  logic             vote,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic [2:0]       lane_fault,
   output logic [CNT_W-1:0] err_cnt,
   output logic [1:0]       state
);

   localparam logic [1:0] ST_NORMAL   = 2'b00;
   localparam logic [1:0] ST_DEGRADED = 2'b01;
   localparam logic [1:0] ST_FAILED   = 2'b10;

   localparam logic [3:0] THRESH_C = 4'(THRESH);

   logic [1:0]       state_q, state_d;
   logic [2:0]       fault_q, fault_d;
   logic [2:0][3:0]  run_q, run_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             out_valid_q, out_valid_d;
   logic             out_bit_q, out_bit_d;

   logic             accept;
   logic             clr;
   logic             sel_bit;
   logic             disagree;
   logic [2:0]       mismatch;

`ifdef VOTE_MONITOR_CLEAR_EN
   assign clr = fault_clr;
`else
   assign clr = 1'b0;
`endif

   // Handshake: accept only when the output slot is free or draining, never in FAILED.
   assign in_ready = (!out_valid_q || out_ready) && (state_q != ST_FAILED);
   assign accept   = in_valid && in_ready;
   assign mismatch = lanes ^ {3{vote}};

   // Result selection and disagreement detection, both from the pre-update state.
   always_comb begin
      // NOTE: every variable written here gets a default first, otherwise
      // a path that skips an assignment infers a latch.
      sel_bit  = vote;
      disagree = 1'b0;
      case (state_q)
         ST_NORMAL: begin
            sel_bit  = vote;
            disagree = |mismatch;
         end
         ST_DEGRADED: begin
            // Exactly one lane is faulty: lane 0 if healthy, else lane 1.
            sel_bit  = fault_q[0] ? lanes[1] : lanes[0];
            // With two healthy lanes, their parity is 1 exactly when they differ.
            disagree = ^(lanes & ~fault_q);
         end
         default: begin
            sel_bit  = vote;
            disagree = 1'b0;
         end
      endcase
   end

   // Run counters, sticky faults, error count and health state for the next edge.
   always_comb begin
      run_d   = run_q;
      fault_d = fault_q;
      err_d   = err_q;
      state_d = state_q;

      if (accept) begin
         for (int i = 0; i < 3; i++) begin
            if (!fault_q[i]) begin
               if (!mismatch[i]) begin
                  run_d[i] = 4'd0;
               end else if (run_q[i] != THRESH_C) begin
                  run_d[i] = run_q[i] + 4'd1;
               end
               if (run_d[i] == THRESH_C) begin
                  fault_d[i] = 1'b1;
               end
            end
         end
         if (disagree && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + CNT_W'(1);
         end
      end

      if (clr) begin
         run_d   = '0;
         fault_d = '0;
         err_d   = '0;
      end

      case (fault_d)
         3'b000:                 state_d = ST_NORMAL;
         3'b001, 3'b010, 3'b100: state_d = ST_DEGRADED;
         default:                state_d = ST_FAILED;
      endcase
   end

   // One-deep output register: load on accept, hold on stall, empty on consume.
   always_comb begin
      out_valid_d = out_valid_q;
      out_bit_d   = out_bit_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_bit_d   = sel_bit;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values; blocking here would create ordering races.
      if (rst) begin
         // NOTE: the run counters are a small register array, not a RAM, so
         // they are reset together with the rest of the state.
         run_q       <= '0;
         fault_q     <= '0;
         err_q       <= '0;
         state_q     <= ST_NORMAL;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
      end else begin
         run_q       <= run_d;
         fault_q     <= fault_d;
         err_q       <= err_d;
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_bit    = out_bit_q;
   assign lane_fault = fault_q;
   assign err_cnt    = err_q;
   assign state      = state_q;

endmodule

// File: doc/vote_monitor.md
VOTE_MONITOR -- requirements
Module: vote_monitor

Interface
REQ-001 SHALL have parameter THRESH, default 4: consecutive per-lane mismatches that declare a lane faulty (range 1..15).
REQ-002 SHALL have parameter CNT_W, default 8: width of err_cnt.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream voter stage presents a sample.
REQ-006 SHALL have port in_ready  output  1  sample accepted when in_valid & in_ready.
REQ-007 SHALL have port lanes  input  3  raw redundant lane bits; bit i is lane i.
REQ-008 SHALL have port vote  input  1  majority of lanes, produced by the upstream voter.
REQ-009 SHALL have port out_valid  input/output direction: output  1  out_bit holds a valid result.
REQ-010 SHALL have port out_ready  input  1  downstream consumes when out_valid & out_ready.
REQ-011 SHALL have port out_bit  output  1  selected result bit.
REQ-012 SHALL have port lane_fault  output  3  sticky per-lane fault flags.
REQ-013 SHALL have port err_cnt  output  CNT_W  saturating disagreement-event count.
REQ-014 SHALL have port state  output  2  00 NORMAL, 01 DEGRADED, 10 FAILED.

Function
REQ-015 SHALL assert in_ready = (!out_valid | out_ready) & (state != FAILED), combinationally.
REQ-016 SHALL register each accepted sample's result into out_bit/out_valid one cycle after acceptance; out_bit and out_valid SHALL hold while out_valid & !out_ready.
REQ-017 SHALL deassert out_valid after a consumed result when no new sample is accepted in that cycle; consume and accept in the same cycle SHALL produce back-to-back results with no bubble.
REQ-018 SHALL, per accepted sample, update each non-faulty lane's run counter: mismatch (lanes[i] != vote) increments it, saturating at THRESH; match clears it to 0.
REQ-019 SHALL set lane_fault[i] in the same cycle that lane i's run counter reaches THRESH; the flag SHALL stay set until reset (or clear, see Configuration).
REQ-020 SHALL select out_bit = vote in NORMAL; in DEGRADED, out_bit = lane bit of the lowest-index non-faulty lane.
REQ-021 SHALL increment err_cnt by 1 per accepted sample when any lane differs from vote (NORMAL) or when the two healthy lanes differ (DEGRADED); it SHALL saturate at all-ones.
REQ-022 SHALL transition NORMAL->DEGRADED when exactly one lane_fault bit is set; NORMAL or DEGRADED->FAILED when two or more are set, including two lanes reaching THRESH on the same sample.
REQ-023 SHALL use the pre-update state for out_bit selection on the sample that triggers a transition.
REQ-024 SHALL, in FAILED, hold in_ready low and allow a pending result to drain; no new results until reset.

Reset
REQ-025 SHALL, while rst is high, force out_valid=0, out_bit=0, lane_fault=000, err_cnt=0, run counters=0, state=NORMAL, independent of clk.
REQ-026 SHALL discard any pending output on reset mid-transfer; first acceptance is possible in the first clk edge after rst falls.

Configuration
REQ-027 SHALL, when VOTE_MONITOR_CLEAR_EN is defined, add input fault_clr (1 bit): a high sample at a clk edge clears lane_fault, run counters and err_cnt and returns state to NORMAL; a sample accepted in that same cycle is still forwarded using the pre-clear selection.
REQ-028 SHALL, when VOTE_MONITOR_CLEAR_EN is undefined, omit fault_clr entirely; faults clear only on rst.

Verification
REQ-029 SHALL test: lanes=111, vote=1, out_ready=1, 8 samples -> out_bit=1 each, one cycle latency, err_cnt=0, state=00.
REQ-030 SHALL test: lanes=110 (lane 0 low), vote=1, 4 consecutive samples -> lane_fault=001 after 4th, state=01, err_cnt=4; then lanes=011 -> out_bit=1 (lane 1).
REQ-031 SHALL test: lane 0 mismatches 3 times, then matches, then mismatches 3 times -> lane_fault=000, err_cnt=6.
REQ-032 SHALL test: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after first accept, out_bit held; out_ready=1 -> back-to-back results, no sample lost or duplicated.
REQ-033 SHALL test: lanes 1 and 2 both mismatch for 4 samples (vote forced) -> state 00->10 directly, in_ready=0; rst pulse mid-stream -> all outputs zero, state=00.
REQ-034 SHALL test, with VOTE_MONITOR_CLEAR_EN: reach state=01, pulse fault_clr -> lane_fault=000, err_cnt=0, state=00 next cycle.
